// File: rtl/rip_fifo_pkg.sv
// Shared types and sizing helpers for the rip FIFO family.
package rip_fifo_pkg;

   // Per-cycle FIFO operation, indexed as {write_accepted, read_accepted}.
   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_BOTH = 2'b11
   } fifo_op_e;

   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int unsigned ptr_width(input int unsigned depth);
      return ($clog2(depth) < 1) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/rip_fifo_wrap_ctr.sv
// Pointer register that advances on inc_i and wraps MAX-1 -> 0 by compare,
// so MAX need not be a power of two. Synchronous active-high reset.
module rip_fifo_wrap_ctr
   import rip_fifo_pkg::*;
#(
   parameter  int unsigned MAX = 16,
   localparam int unsigned PW  = ptr_width(MAX)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          inc_i,
   output logic [PW-1:0] ptr_o
);

   logic [PW-1:0] ptr_q;
   logic [PW-1:0] ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (inc_i) begin
         if (ptr_q == PW'(MAX - 1)) begin
            ptr_d = '0;
         end else begin
            ptr_d = ptr_q + PW'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/rip_fifo_sync.sv
// Single-clock first-word-fall-through FIFO with occupancy count and
// almost-full/almost-empty flags. Sticky overflow/underflow flags are built
// only when RIP_FIFO_SYNC_ERR_EN is defined; otherwise those ports read 0.
module rip_fifo_sync
   import rip_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 128,
   parameter int unsigned DEPTH         = 16,
   parameter int unsigned AFULL_THRESH  = DEPTH - 2,
   parameter int unsigned AEMPTY_THRESH = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          w_en,
   input  logic [DATA_WIDTH-1:0]         w_data,
   input  logic                          r_en,
   output logic [DATA_WIDTH-1:0]         r_data,
   output logic                          w_full,
   output logic                          r_empty,
   output logic                          almost_full,
   output logic                          almost_empty,
   output logic [cnt_width(DEPTH)-1:0]   count,
   input  logic                          err_clr,
   output logic                          overflow,
   output logic                          underflow
);

   localparam int unsigned CW = cnt_width(DEPTH);
   localparam int unsigned PW = ptr_width(DEPTH);

   if (DATA_WIDTH < 1) begin : g_chk_width
      $error("rip_fifo_sync: DATA_WIDTH must be >= 1");
   end
   if (DEPTH < 2) begin : g_chk_depth
      $error("rip_fifo_sync: DEPTH must be >= 2");
   end
   if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_chk_afull
      $error("rip_fifo_sync: AFULL_THRESH must be in 1..DEPTH");
   end
   if (AEMPTY_THRESH > DEPTH - 1) begin : g_chk_aempty
      $error("rip_fifo_sync: AEMPTY_THRESH must be in 0..DEPTH-1");
   end

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]         w_ptr;
   logic [PW-1:0]         r_ptr;

   logic [CW-1:0] count_q,  count_d;
   logic          full_q,   full_d;
   logic          empty_q,  empty_d;
   logic          afull_q,  afull_d;
   logic          aempty_q, aempty_d;

   logic     wr_acc;
   logic     rd_acc;
   fifo_op_e op;

   // Acceptance looks only at registered flags, so a write while full is
   // dropped even if a read frees a slot in the same cycle (and vice versa).
   assign wr_acc = w_en && !full_q;
   assign rd_acc = r_en && !empty_q;

   rip_fifo_wrap_ctr #(
      .MAX (DEPTH)
   ) u_w_ptr (
      .clk_i (clk),
      .rst_i (rst),
      .inc_i (wr_acc),
      .ptr_o (w_ptr)
   );

   rip_fifo_wrap_ctr #(
      .MAX (DEPTH)
   ) u_r_ptr (
      .clk_i (clk),
      .rst_i (rst),
      .inc_i (rd_acc),
      .ptr_o (r_ptr)
   );

   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem_q[w_ptr] <= w_data;
      end
   end

   assign r_data = mem_q[r_ptr];

   always_comb begin
      op      = fifo_op_e'({wr_acc, rd_acc});
      count_d = count_q;
      case (op)
         OP_PUSH: count_d = count_q + CW'(1);
         OP_POP:  count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      full_d   = (count_d == CW'(DEPTH));
      empty_d  = (count_d == '0);
      afull_d  = (count_d >= CW'(AFULL_THRESH));
      aempty_d = (count_d <= CW'(AEMPTY_THRESH));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         afull_q  <= 1'b0;
         aempty_q <= 1'b1;
      end else begin
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         afull_q  <= afull_d;
         aempty_q <= aempty_d;
      end
   end

   assign count        = count_q;
   assign w_full       = full_q;
   assign r_empty      = empty_q;
   assign almost_full  = afull_q;
   assign almost_empty = aempty_q;

`ifdef RIP_FIFO_SYNC_ERR_EN
   logic ovf_q, ovf_d;
   logic udf_q, udf_d;

   // A new error in the same cycle as err_clr wins, keeping the flag set.
   always_comb begin
      ovf_d = (ovf_q && !err_clr) || (w_en && full_q);
      udf_d = (udf_q && !err_clr) || (r_en && empty_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

   assign overflow  = ovf_q;
   assign underflow = udf_q;
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr;
   assign overflow       = 1'b0;
   assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_rip_fifo_sync.sv
// Directed bench for rip_fifo_sync (DEPTH=6, 8-bit data) with a queue
// scoreboard; error-flag expectations follow RIP_FIFO_SYNC_ERR_EN.
module tb_rip_fifo_sync;

   localparam int unsigned DW  = 8;
   localparam int unsigned DEP = 6;
   localparam int unsigned AF  = 4;
   localparam int unsigned AE  = 1;
`ifdef RIP_FIFO_SYNC_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          w_en;
   logic [DW-1:0] w_data;
   logic          r_en;
   logic [DW-1:0] r_data;
   logic          w_full;
   logic          r_empty;
   logic          almost_full;
   logic          almost_empty;
   logic [2:0]    count;
   logic          err_clr;
   logic          overflow;
   logic          underflow;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   logic [DW-1:0] sb[$];
   bit            m_ovf;
   bit            m_udf;

   always #5 clk = ~clk;

   rip_fifo_sync #(
      .DATA_WIDTH    (DW),
      .DEPTH         (DEP),
      .AFULL_THRESH  (AF),
      .AEMPTY_THRESH (AE)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .w_en         (w_en),
      .w_data       (w_data),
      .r_en         (r_en),
      .r_data       (r_data),
      .w_full       (w_full),
      .r_empty      (r_empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .err_clr      (err_clr),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_state();
      int unsigned c;
      c = sb.size();
      chk("count",        32'(count),        32'(c));
      chk("w_full",       32'(w_full),       32'(c == DEP));
      chk("r_empty",      32'(r_empty),      32'(c == 0));
      chk("almost_full",  32'(almost_full),  32'(c >= AF));
      chk("almost_empty", 32'(almost_empty), 32'(c <= AE));
      chk("overflow",     32'(overflow),     32'(m_ovf));
      chk("underflow",    32'(underflow),    32'(m_udf));
      if (c > 0) chk("head", 32'(r_data), 32'(sb[0]));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      sb.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      check_state();
   endtask

   // Drive one cycle, update the model from pre-edge state, then check.
   task automatic cycle(input bit we, input logic [DW-1:0] wd, input bit re, input bit clr);
      bit wr, rd;
      int unsigned c;
      c  = sb.size();
      w_en = we; w_data = wd; r_en = re; err_clr = clr;
      wr = we && (c < DEP);
      rd = re && (c > 0);
      m_ovf = ERR_EN && ((m_ovf && !clr) || (we && c == DEP));
      m_udf = ERR_EN && ((m_udf && !clr) || (re && c == 0));
      if (rd) chk("pop_data", 32'(r_data), 32'(sb.pop_front()));
      if (wr) sb.push_back(wd);
      @(posedge clk); #1;
      w_en = 1'b0; r_en = 1'b0; err_clr = 1'b0;
      check_state();
   endtask

   initial begin
      rst = 1'b1; w_en = 1'b0; w_data = '0; r_en = 1'b0; err_clr = 1'b0;
      m_ovf = 1'b0; m_udf = 1'b0;
      @(posedge clk); #1;
      do_reset();
      cycle(1'b0, 8'h00, 1'b0, 1'b0);

      for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);

      cycle(1'b1, 8'hAA, 1'b0, 1'b0);
      cycle(1'b1, 8'hAB, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);

      for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
      chk("count_after_both", 32'(count), 32'd3);
      for (int i = 0; i < 40; i++)
         cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);

      while (sb.size() > 0) cycle(1'b0, 8'h00, 1'b1, 1'b0);
      cycle(1'b1, 8'h5A, 1'b1, 1'b0);
      chk("fwft_5a", 32'(r_data), 32'h5A);

      for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
      do_reset();

      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b1);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
      cycle(1'b1, 8'hEE, 1'b0, 1'b1);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
